// File: rtl/spi_syncer.sv
// -----------------------------------------------------------------------------
// spi_syncer
//
// Pairs the local player's location (from this FPGA's tracker) with the
// opponent's state frame, which arrives MSB-first over a 3-wire SPI-style
// link from the other FPGA. Once both halves are held, they are presented
// together with a one-cycle valid strobe. Everything runs in the clk_pixel
// domain; the three serial pins are asynchronous and are synchronized here.
//
// Ports
//   clk_pixel_in         in   system clock (only clock)
//   rst_in               in   synchronous, active-low reset
//   location_in          in   local player location
//   location_in_valid    in   one-cycle strobe qualifying location_in
//   data_in              in   serial data, async, MSB first
//   data_clk_in          in   serial clock, async, sampled on rising edge
//   sel_in               in   frame select, async, active-low
//   player_location_out  out  paired local location
//   opponent_data_out    out  paired opponent frame
//   data_out_valid       out  one-cycle strobe, both outputs valid
//
// Build option
//   SYNCER_HEADER_CHECK_EN  when defined, a completed frame is kept only if
//                           its top three bits are 3'b101; otherwise every
//                           complete frame is kept.
// -----------------------------------------------------------------------------
module spi_syncer #(
    parameter int DATA_WIDTH  = 89,
    parameter int LOC_WIDTH   = 63,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk_pixel_in,
    input  logic                  rst_in,
    input  logic [LOC_WIDTH-1:0]  location_in,
    input  logic                  location_in_valid,
    input  logic                  data_in,
    input  logic                  data_clk_in,
    input  logic                  sel_in,
    output logic [LOC_WIDTH-1:0]  player_location_out,
    output logic [DATA_WIDTH-1:0] opponent_data_out,
    output logic                  data_out_valid
);

    localparam int               CNT_W    = $clog2(DATA_WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_WIDTH);

    // synchronizer chains; the last stage is the usable value
    logic [SYNC_STAGES-1:0] data_sync_q, data_sync_d;
    logic [SYNC_STAGES-1:0] clk_sync_q,  clk_sync_d;
    logic [SYNC_STAGES-1:0] sel_sync_q,  sel_sync_d;

    logic                  clk_prev_q, clk_prev_d;
    logic                  sel_prev_q, sel_prev_d;
    logic [CNT_W-1:0]      bit_cnt_q,  bit_cnt_d;
    logic [DATA_WIDTH-1:0] shift_q,    shift_d;
    logic [DATA_WIDTH-1:0] opp_buf_q,  opp_buf_d;
    logic                  opp_have_q, opp_have_d;
    logic [LOC_WIDTH-1:0]  loc_buf_q,  loc_buf_d;
    logic                  loc_have_q, loc_have_d;
    logic [LOC_WIDTH-1:0]  loc_out_q,  loc_out_d;
    logic [DATA_WIDTH-1:0] opp_out_q,  opp_out_d;
    logic                  valid_q,    valid_d;

    logic                  data_s, clk_s, sel_s;
    logic                  clk_rise, sel_fall;
    logic                  frame_done, hdr_ok;
    logic [DATA_WIDTH-1:0] frame_full;

    assign data_s = data_sync_q[SYNC_STAGES-1];
    assign clk_s  = clk_sync_q[SYNC_STAGES-1];
    assign sel_s  = sel_sync_q[SYNC_STAGES-1];

    assign clk_rise   = clk_s & ~clk_prev_q;
    assign sel_fall   = ~sel_s & sel_prev_q;
    assign frame_full = {shift_q[DATA_WIDTH-2:0], data_s};

    always_comb begin
`ifdef SYNCER_HEADER_CHECK_EN
        hdr_ok = (frame_full[DATA_WIDTH-1 -: 3] == 3'b101);
`else
        hdr_ok = 1'b1;
`endif
    end

    always_comb begin
        data_sync_d = {data_sync_q[SYNC_STAGES-2:0], data_in};
        clk_sync_d  = {clk_sync_q[SYNC_STAGES-2:0],  data_clk_in};
        sel_sync_d  = {sel_sync_q[SYNC_STAGES-2:0],  sel_in};
        clk_prev_d  = clk_s;
        sel_prev_d  = sel_s;

        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        opp_buf_d   = opp_buf_q;
        opp_have_d  = opp_have_q;
        loc_buf_d   = loc_buf_q;
        loc_have_d  = loc_have_q;
        loc_out_d   = loc_out_q;
        opp_out_d   = opp_out_q;
        valid_d     = 1'b0;
        frame_done  = 1'b0;

        // receive: sel high (idle or abort) discards any partial frame;
        // once the counter saturates, extra edges are ignored until a new
        // sel falling edge restarts the frame
        if (sel_s) begin
            bit_cnt_d = '0;
            shift_d   = '0;
        end else if (sel_fall) begin
            bit_cnt_d = '0;
        end else if (clk_rise && (bit_cnt_q != CNT_FULL)) begin
            shift_d   = frame_full;
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
            frame_done = (bit_cnt_q == CNT_LAST);
        end

        // pairing consumes the held halves; a capture landing in the same
        // cycle below re-arms its flag for the next pairing
        if (loc_have_q && opp_have_q) begin
            loc_out_d  = loc_buf_q;
            opp_out_d  = opp_buf_q;
            valid_d    = 1'b1;
            loc_have_d = 1'b0;
            opp_have_d = 1'b0;
        end

        if (location_in_valid) begin
            loc_buf_d  = location_in;
            loc_have_d = 1'b1;
        end

        if (frame_done && hdr_ok) begin
            opp_buf_d  = frame_full;
            opp_have_d = 1'b1;
        end
    end

    always_ff @(posedge clk_pixel_in) begin
        if (!rst_in) begin
            data_sync_q <= '0;
            clk_sync_q  <= '0;
            sel_sync_q  <= '1;
            clk_prev_q  <= 1'b0;
            sel_prev_q  <= 1'b1;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            opp_buf_q   <= '0;
            opp_have_q  <= 1'b0;
            loc_buf_q   <= '0;
            loc_have_q  <= 1'b0;
            loc_out_q   <= '0;
            opp_out_q   <= '0;
            valid_q     <= 1'b0;
        end else begin
            data_sync_q <= data_sync_d;
            clk_sync_q  <= clk_sync_d;
            sel_sync_q  <= sel_sync_d;
            clk_prev_q  <= clk_prev_d;
            sel_prev_q  <= sel_prev_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            opp_buf_q   <= opp_buf_d;
            opp_have_q  <= opp_have_d;
            loc_buf_q   <= loc_buf_d;
            loc_have_q  <= loc_have_d;
            loc_out_q   <= loc_out_d;
            opp_out_q   <= opp_out_d;
            valid_q     <= valid_d;
        end
    end

    assign player_location_out = loc_out_q;
    assign opponent_data_out   = opp_out_q;
    assign data_out_valid      = valid_q;

endmodule

// File: tb/tb_spi_syncer.sv
module tb_spi_syncer;

    logic          clk_pixel_in = 1'b0;
    logic          rst_in = 1'b0;
    logic [62:0]   location_in = '0;
    logic          location_in_valid = 1'b0;
    logic          data_in = 1'b0;
    logic          data_clk_in = 1'b0;
    logic          sel_in = 1'b1;
    logic [62:0]   player_location_out;
    logic [88:0]   opponent_data_out;
    logic          data_out_valid;

    int compared = 0;
    int mismatched = 0;

    // expected pairs, {location, frame}
    logic [151:0] exp_q[$];

    localparam logic [88:0] F1 = {3'b101, 11'b00000100001, 75'h2A5123456789ABCDEF0};
    localparam logic [62:0] L1 = {11'b11100100001, 10'b1111111010, 42'h2ABCDEF0123};
    localparam logic [88:0] F2 = {3'b101, 11'b00011101101, 75'h13579BDF02468ACE135};
    localparam logic [62:0] L2 = {11'b00000100001, 52'h0F0F0F0F0F0F0};
    localparam logic [88:0] F3 = {3'b101, 11'b00000100001, 10'b1010101010, 11'b11111011011, 54'h155555AAAA3333};
    localparam logic [62:0] L3 = {11'b01010101011, 52'hDEADBEEFCAFE1};
    localparam logic [88:0] FP = {3'b101, 86'h3FFFFFFFFFFFFFFFFFFFFF};
    localparam logic [88:0] F4 = {3'b101, 86'h0123456789ABCDEF012345};
    localparam logic [62:0] L4 = 63'h1234_5678_9ABC_DEF0;
    localparam logic [62:0] LX = 63'h7FFF_0000_FFFF_0000;
    localparam logic [88:0] F5 = {3'b101, 86'h2FEDCBA9876543210FEDCB};
    localparam logic [62:0] L5 = 63'h0A0A_0B0B_0C0C_0D0D;
    localparam logic [88:0] FB = {3'b011, 86'h155555555555555555AAAA};
    localparam logic [62:0] L6 = 63'h3333_4444_5555_6666;
    localparam logic [88:0] F7 = {3'b101, 86'h0000000000000000000001};
    localparam logic [88:0] F8 = {3'b101, 86'h2AAAAAAAAAAAAAAAAAAAAA};
    localparam logic [62:0] L8 = 63'h5555_5555_5555_5555;

    spi_syncer dut (
        .clk_pixel_in        (clk_pixel_in),
        .rst_in              (rst_in),
        .location_in         (location_in),
        .location_in_valid   (location_in_valid),
        .data_in             (data_in),
        .data_clk_in         (data_clk_in),
        .sel_in              (sel_in),
        .player_location_out (player_location_out),
        .opponent_data_out   (opponent_data_out),
        .data_out_valid      (data_out_valid)
    );

    always #5 clk_pixel_in = ~clk_pixel_in;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation still running at 1 ms, required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [151:0] act, input logic [151:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // monitor: every valid pulse must match the oldest expected pair
    always @(negedge clk_pixel_in) begin
        if (data_out_valid) begin
            if (exp_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_pulse: got pulse loc=%0h data=%0h, expected no pulse",
                         player_location_out, opponent_data_out);
            end else begin
                logic [151:0] e;
                e = exp_q.pop_front();
                check("pair_loc",  152'(player_location_out), 152'(e[151:89]));
                check("pair_data", 152'(opponent_data_out),   152'(e[88:0]));
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk_pixel_in);
    endtask

    task automatic pulse_loc(input logic [62:0] loc);
        location_in       = loc;
        location_in_valid = 1'b1;
        @(negedge clk_pixel_in);
        location_in_valid = 1'b0;
    endtask

    // drives nbits of frame MSB first; optional location strobe after loc_at bits
    task automatic send_frame(input logic [88:0] frame, input int nbits, input int half,
                              input int loc_at, input logic [62:0] loc, input bit raise_sel);
        sel_in = 1'b0;
        cycles(half);
        for (int i = 0; i < nbits; i++) begin
            if (loc_at == i) pulse_loc(loc);
            cycles(half / 2);
            data_in = frame[88-i];
            cycles(half - half / 2);
            data_clk_in = 1'b1;
            cycles(half);
            data_clk_in = 1'b0;
        end
        cycles(half);
        if (raise_sel) begin
            sel_in = 1'b1;
            cycles(half);
        end
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            cycles(1);
            n++;
        end
        compared++;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL %s: got %0d pulses still missing, expected 0", name, exp_q.size());
            exp_q.delete();
        end
        cycles(20);
    endtask

    initial begin
        cycles(3);
        check("rst_valid", 152'(data_out_valid), 152'(0));
        check("rst_loc",   152'(player_location_out), 152'(0));
        check("rst_data",  152'(opponent_data_out), 152'(0));
        rst_in = 1'b1;
        cycles(5);

        // location strobe mid-frame
        exp_q.push_back({L1, F1});
        send_frame(F1, 89, 4, 15, L1, 1);
        drain("loc_mid_frame");

        // location before frame
        pulse_loc(L2);
        exp_q.push_back({L2, F2});
        cycles(10);
        send_frame(F2, 89, 4, -1, '0, 1);
        drain("loc_before_frame");

        // location after sel rises: pulse exactly 2 cycles after the strobe
        send_frame(F3, 89, 4, -1, '0, 1);
        cycles(10);
        check("no_pulse_without_loc", 152'(exp_q.size()), 152'(0));
        exp_q.push_back({L3, F3});
        location_in       = L3;
        location_in_valid = 1'b1;
        @(negedge clk_pixel_in);
        location_in_valid = 1'b0;
        check("lat_cycle1_valid", 152'(data_out_valid), 152'(0));
        @(negedge clk_pixel_in);
        check("lat_cycle2_valid", 152'(data_out_valid), 152'(1));
        drain("loc_after_frame");

        // aborted partial frame, then a full one
        send_frame(FP, 40, 4, -1, '0, 1);
        send_frame(F5, 89, 4, -1, '0, 1);
        exp_q.push_back({L5, F5});
        pulse_loc(L5);
        drain("abort_then_full");

        // reset mid-frame discards frame and held location
        pulse_loc(LX);
        send_frame(F1, 30, 4, -1, '0, 0);
        rst_in = 1'b0;
        cycles(2);
        check("midrst_valid", 152'(data_out_valid), 152'(0));
        check("midrst_loc",   152'(player_location_out), 152'(0));
        check("midrst_data",  152'(opponent_data_out), 152'(0));
        rst_in = 1'b1;
        sel_in = 1'b1;
        cycles(10);
        send_frame(F4, 89, 4, -1, '0, 1);
        cycles(20);
        exp_q.push_back({L4, F4});
        pulse_loc(L4);
        drain("after_mid_reset");

        // bad header
`ifndef SYNCER_HEADER_CHECK_EN
        exp_q.push_back({L6, FB});
`endif
        send_frame(FB, 89, 4, -1, '0, 1);
        pulse_loc(L6);
        cycles(20);
`ifdef SYNCER_HEADER_CHECK_EN
        exp_q.push_back({L6, F7});
        send_frame(F7, 89, 4, -1, '0, 1);
`endif
        drain("bad_header");

        // 1 MHz serial clock against 100 MHz system clock
        pulse_loc(L8);
        exp_q.push_back({L8, F8});
        send_frame(F8, 89, 50, -1, '0, 1);
        drain("slow_link");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
